// File: rtl/color_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : color_game_ctrl
//  Description : Round sequencer for the colour-match game. Requests a new
//                colour from the LFSR generator, captures it as the round
//                target, times the player's guess, and tracks score and lives
//                until the game is won or all lives are spent.
//  Revision    : 1.0  initial release
// ============================================================================
module color_game_ctrl #(
    parameter int ROUND_TIME = 5,   // seconds allowed per guess (1..15)
    parameter int LIVES      = 3,   // misses allowed per game (1..7)
    parameter int WIN_SCORE  = 20   // hits needed to win (1..255)
) (
    input  logic       clk1Hz,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] guess,
    input  logic       guess_valid,
    input  logic [2:0] color,
    output logic       change,
    output logic [2:0] target,
    output logic [3:0] timer,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic       hit_led,
    output logic       miss_led,
    output logic       game_over,
    output logic       win,
    output logic [2:0] state
);

    // Debug/display codes are fixed: the score/LED board decodes them directly.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NEXT = 3'd1,
        SHOW = 3'd2,
        WAIT = 3'd3,
        HIT  = 3'd4,
        MISS = 3'd5,
        OVER = 3'd6
    } state_t;

    // The timer counts down to zero inclusive, so a round lasts ROUND_TIME cycles.
    localparam logic [3:0] c_TIMER_LOAD = 4'(ROUND_TIME - 1);
    localparam logic [2:0] c_LIVES      = 3'(LIVES);
    localparam logic [7:0] c_WIN_SCORE  = 8'(WIN_SCORE);
    localparam logic [2:0] c_BLACK      = 3'b000;

    state_t     r_state;
    logic [2:0] r_target;
    logic [3:0] r_timer;
    logic [7:0] r_score;
    logic [2:0] r_lives;
    logic       r_win;

    state_t     w_state_nxt;
    logic [2:0] w_target_nxt;
    logic [3:0] w_timer_nxt;
    logic [7:0] w_score_nxt;
    logic [2:0] w_lives_nxt;
    logic       w_win_nxt;

    // Score never exceeds WIN_SCORE-1 before a hit, so 8 bits cannot wrap here.
    logic [7:0] w_score_inc;
    logic       w_guess_match;

    assign w_score_inc   = r_score + 8'd1;
    assign w_guess_match = (guess == r_target);

    // State and game registers; rst returns to IDLE immediately, not on a clock.
    always_ff @(posedge clk1Hz or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= 3'd0;
            r_timer  <= 4'd0;
            r_score  <= 8'd0;
            r_lives  <= 3'd0;
            r_win    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_timer  <= w_timer_nxt;
            r_score  <= w_score_nxt;
            r_lives  <= w_lives_nxt;
            r_win    <= w_win_nxt;
        end
    end

    // Next-state and register-update decisions; everything holds unless a state acts on it.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_timer_nxt  = r_timer;
        w_score_nxt  = r_score;
        w_lives_nxt  = r_lives;
        w_win_nxt    = r_win;

        case (r_state)
            IDLE: begin
                // No round is active, so no target is shown.
                w_target_nxt = 3'd0;
                if (start) begin
                    w_state_nxt = NEXT;
                    w_score_nxt = 8'd0;
                    w_lives_nxt = c_LIVES;
                    w_win_nxt   = 1'b0;
                end
            end

            NEXT: begin
                // The generator advances on this edge; its new colour is seen in SHOW.
                w_state_nxt = SHOW;
            end

            SHOW: begin
                if (color == c_BLACK) begin
                    // Black cannot be matched by the player: draw again, free of charge.
                    w_state_nxt = NEXT;
                end else begin
                    w_target_nxt = color;
                    w_timer_nxt  = c_TIMER_LOAD;
                    w_state_nxt  = WAIT;
                end
            end

            WAIT: begin
                // A guess on the final second still counts, so it outranks timeout.
                if (guess_valid) begin
                    w_state_nxt = w_guess_match ? HIT : MISS;
                end else if (r_timer == 4'd0) begin
                    w_state_nxt = MISS;
                end else begin
                    w_timer_nxt = r_timer - 4'd1;
                end
            end

            HIT: begin
                w_score_nxt = w_score_inc;
                if (w_score_inc == c_WIN_SCORE) begin
                    w_state_nxt = OVER;
                    w_win_nxt   = 1'b1;
                end else begin
                    w_state_nxt = NEXT;
                end
            end

            MISS: begin
                w_lives_nxt = r_lives - 3'd1;
                if (r_lives == 3'd1) begin
                    w_state_nxt = OVER;
                    w_win_nxt   = 1'b0;
                end else begin
                    w_state_nxt = NEXT;
                end
            end

            OVER: begin
                // Final score, lives, result and target stay on the display until restart.
                if (start) begin
                    w_state_nxt = NEXT;
                    w_score_nxt = 8'd0;
                    w_lives_nxt = c_LIVES;
                    w_win_nxt   = 1'b0;
                end
            end

            default: begin
                // Unused code 7 recovers to IDLE.
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Per-state strobes decoded from the state register so they are glitch-free.
    always_comb begin
        change    = 1'b0;
        hit_led   = 1'b0;
        miss_led  = 1'b0;
        game_over = 1'b0;
        case (r_state)
            NEXT:    change    = 1'b1;
            HIT:     hit_led   = 1'b1;
            MISS:    miss_led  = 1'b1;
            OVER:    game_over = 1'b1;
            default: ;
        endcase
    end

    assign target = r_target;
    assign timer  = r_timer;
    assign score  = r_score;
    assign lives  = r_lives;
    assign win    = r_win;
    assign state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_color_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_color_game_ctrl
//  Description : Self-checking bench for color_game_ctrl. Each scenario queues
//                stimulus together with the expected outputs after the
//                following clock edge, then replays the queue against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_color_game_ctrl;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_NEXT = 3'd1;
    localparam logic [2:0] c_SHOW = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_HIT  = 3'd4;
    localparam logic [2:0] c_MISS = 3'd5;
    localparam logic [2:0] c_OVER = 3'd6;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [2:0] guess;
        logic       gv;
        logic [2:0] color;
        logic       noclk;   // apply and sample without waiting for a clock edge
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       chg;
        logic [2:0] tgt;
        logic [3:0] tmr;
        logic [7:0] sc;
        logic [2:0] lv;
        logic       hit;
        logic       miss;
        logic       go;
        logic       win;
    } obs_t;

    logic clk1Hz = 1'b0;
    always #5 clk1Hz = ~clk1Hz;

    logic       rst;
    logic       start;
    logic [2:0] guess;
    logic       guess_valid;
    logic [2:0] color;

    logic       a_change, a_hit, a_miss, a_go, a_win;
    logic [2:0] a_target, a_lives, a_state;
    logic [3:0] a_timer;
    logic [7:0] a_score;

    logic       b_change, b_hit, b_miss, b_go, b_win;
    logic [2:0] b_target, b_lives, b_state;
    logic [3:0] b_timer;
    logic [7:0] b_score;

    obs_t w_obs_a;
    obs_t w_obs_b;

    assign w_obs_a = {a_state, a_change, a_target, a_timer, a_score, a_lives,
                      a_hit, a_miss, a_go, a_win};
    assign w_obs_b = {b_state, b_change, b_target, b_timer, b_score, b_lives,
                      b_hit, b_miss, b_go, b_win};

    color_game_ctrl dut_a (
        .clk1Hz      (clk1Hz),
        .rst         (rst),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .color       (color),
        .change      (a_change),
        .target      (a_target),
        .timer       (a_timer),
        .score       (a_score),
        .lives       (a_lives),
        .hit_led     (a_hit),
        .miss_led    (a_miss),
        .game_over   (a_go),
        .win         (a_win),
        .state       (a_state)
    );

    color_game_ctrl #(.WIN_SCORE(2)) dut_b (
        .clk1Hz      (clk1Hz),
        .rst         (rst),
        .start       (start),
        .guess       (guess),
        .guess_valid (guess_valid),
        .color       (color),
        .change      (b_change),
        .target      (b_target),
        .timer       (b_timer),
        .score       (b_score),
        .lives       (b_lives),
        .hit_led     (b_hit),
        .miss_led    (b_miss),
        .game_over   (b_go),
        .win         (b_win),
        .state       (b_state)
    );

    stim_t stim_q[$];
    obs_t  exp_q[$];
    string name_q[$];

    int checks = 0;
    int errors = 0;

    function automatic stim_t sv(input logic r, input logic s, input logic [2:0] g,
                                 input logic v, input logic [2:0] c, input logic nc);
        stim_t x;
        x.rst = r; x.start = s; x.guess = g; x.gv = v; x.color = c; x.noclk = nc;
        return x;
    endfunction

    // Strobes follow from the expected state by their definitions.
    function automatic obs_t ex(input logic [2:0] st, input logic [2:0] tgt,
                                input logic [3:0] tmr, input logic [7:0] sc,
                                input logic [2:0] lv, input logic w);
        obs_t o;
        o.st = st; o.tgt = tgt; o.tmr = tmr; o.sc = sc; o.lv = lv; o.win = w;
        o.chg  = (st == c_NEXT);
        o.hit  = (st == c_HIT);
        o.miss = (st == c_MISS);
        o.go   = (st == c_OVER);
        return o;
    endfunction

    task automatic add(input string nm, input stim_t s, input obs_t e);
        name_q.push_back(nm);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s; obs_t e; obs_t got; string nm;
        add("rst_hold0", sv(1, 0, 0, 0, 0, 0), ex(c_IDLE, 0, 0, 0, 0, 0));
        add("rst_hold1", sv(1, 0, 0, 0, 0, 0), ex(c_IDLE, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            add($sformatf("idle%0d", k), sv(0, 0, 3'b111, 1, 3'b101, 0),
                ex(c_IDLE, 0, 0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_a;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    task automatic test_round_hit();
        stim_t s; obs_t e; obs_t got; string nm;
        add("start",    sv(0, 1, 0,      0, 0,      0), ex(c_NEXT, 0,      0, 0, 3, 0));
        add("show",     sv(0, 0, 3'b101, 1, 3'b101, 0), ex(c_SHOW, 0,      0, 0, 3, 0));
        add("latch",    sv(0, 0, 0,      0, 3'b101, 0), ex(c_WAIT, 3'b101, 4, 0, 3, 0));
        add("hit",      sv(0, 0, 3'b101, 1, 3'b101, 0), ex(c_HIT,  3'b101, 4, 0, 3, 0));
        add("hit_next", sv(0, 1, 0,      0, 3'b101, 0), ex(c_NEXT, 3'b101, 4, 1, 3, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_a;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s; obs_t e; obs_t got; string nm;
        add("show2",  sv(0, 1, 0, 0, 3'b110, 0), ex(c_SHOW, 3'b101, 4, 1, 3, 0));
        add("latch2", sv(0, 0, 0, 0, 3'b110, 0), ex(c_WAIT, 3'b110, 4, 1, 3, 0));
        for (int k = 3; k >= 0; k--)
            add($sformatf("tick%0d", k), sv(0, 1, 0, 0, 3'b110, 0),
                ex(c_WAIT, 3'b110, 4'(k), 1, 3, 0));
        add("timeout",   sv(0, 0, 0, 0, 3'b110, 0), ex(c_MISS, 3'b110, 0, 1, 3, 0));
        add("miss_next", sv(0, 0, 0, 0, 3'b110, 0), ex(c_NEXT, 3'b110, 0, 1, 2, 0));
        add("show3",     sv(0, 0, 0, 0, 3'b001, 0), ex(c_SHOW, 3'b110, 0, 1, 2, 0));
        add("latch3",    sv(0, 0, 0, 0, 3'b001, 0), ex(c_WAIT, 3'b001, 4, 1, 2, 0));
        for (int k = 3; k >= 0; k--)
            add($sformatf("tock%0d", k), sv(0, 0, 0, 0, 3'b001, 0),
                ex(c_WAIT, 3'b001, 4'(k), 1, 2, 0));
        add("late_hit",  sv(0, 0, 3'b001, 1, 3'b001, 0), ex(c_HIT,  3'b001, 0, 1, 2, 0));
        add("late_next", sv(0, 0, 0,      0, 3'b001, 0), ex(c_NEXT, 3'b001, 0, 2, 2, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_a;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    task automatic test_black_retry_over();
        stim_t s; obs_t e; obs_t got; string nm;
        add("show_blk",    sv(0, 0, 0,      0, 3'b000, 0), ex(c_SHOW, 3'b001, 0, 2, 2, 0));
        add("retry",       sv(0, 0, 0,      0, 3'b000, 0), ex(c_NEXT, 3'b001, 0, 2, 2, 0));
        add("show_retry",  sv(0, 0, 0,      0, 3'b011, 0), ex(c_SHOW, 3'b001, 0, 2, 2, 0));
        add("latch_retry", sv(0, 0, 0,      0, 3'b011, 0), ex(c_WAIT, 3'b011, 4, 2, 2, 0));
        add("wrong",       sv(0, 0, 3'b100, 1, 3'b011, 0), ex(c_MISS, 3'b011, 4, 2, 2, 0));
        add("miss2_next",  sv(0, 0, 0,      0, 3'b011, 0), ex(c_NEXT, 3'b011, 4, 2, 1, 0));
        add("show4",       sv(0, 0, 0,      0, 3'b010, 0), ex(c_SHOW, 3'b011, 4, 2, 1, 0));
        add("latch4",      sv(0, 0, 0,      0, 3'b010, 0), ex(c_WAIT, 3'b010, 4, 2, 1, 0));
        add("wrong2",      sv(0, 0, 3'b101, 1, 3'b010, 0), ex(c_MISS, 3'b010, 4, 2, 1, 0));
        add("over",        sv(0, 0, 0,      0, 3'b010, 0), ex(c_OVER, 3'b010, 4, 2, 0, 0));
        add("over_hold",   sv(0, 0, 3'b010, 1, 3'b010, 0), ex(c_OVER, 3'b010, 4, 2, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_a;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    task automatic test_restart_async_reset();
        stim_t s; obs_t e; obs_t got; string nm;
        add("restart",   sv(0, 1, 0, 0, 3'b111, 0), ex(c_NEXT, 3'b010, 4, 0, 3, 0));
        add("show5",     sv(0, 0, 0, 0, 3'b111, 0), ex(c_SHOW, 3'b010, 4, 0, 3, 0));
        add("latch5",    sv(0, 0, 0, 0, 3'b111, 0), ex(c_WAIT, 3'b111, 4, 0, 3, 0));
        add("async_rst", sv(1, 0, 0, 0, 3'b111, 1), ex(c_IDLE, 0, 0, 0, 0, 0));
        add("rst_held",  sv(1, 1, 0, 0, 3'b111, 0), ex(c_IDLE, 0, 0, 0, 0, 0));
        add("rst_rel",   sv(0, 0, 0, 0, 3'b111, 0), ex(c_IDLE, 0, 0, 0, 0, 0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_a;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    // Runs on the WIN_SCORE=2 instance, which was reset alongside the main one.
    task automatic test_win();
        stim_t s; obs_t e; obs_t got; string nm;
        add("w_start",  sv(0, 1, 0,      0, 3'b100, 0), ex(c_NEXT, 0,      0, 0, 3, 0));
        add("w_show",   sv(0, 0, 0,      0, 3'b100, 0), ex(c_SHOW, 0,      0, 0, 3, 0));
        add("w_latch",  sv(0, 0, 0,      0, 3'b100, 0), ex(c_WAIT, 3'b100, 4, 0, 3, 0));
        add("w_hit1",   sv(0, 0, 3'b100, 1, 3'b100, 0), ex(c_HIT,  3'b100, 4, 0, 3, 0));
        add("w_next",   sv(0, 0, 0,      0, 3'b001, 0), ex(c_NEXT, 3'b100, 4, 1, 3, 0));
        add("w_show2",  sv(0, 0, 0,      0, 3'b001, 0), ex(c_SHOW, 3'b100, 4, 1, 3, 0));
        add("w_latch2", sv(0, 0, 0,      0, 3'b001, 0), ex(c_WAIT, 3'b001, 4, 1, 3, 0));
        add("w_hit2",   sv(0, 0, 3'b001, 1, 3'b001, 0), ex(c_HIT,  3'b001, 4, 1, 3, 0));
        add("w_over",   sv(0, 0, 0,      0, 3'b001, 0), ex(c_OVER, 3'b001, 4, 2, 3, 1));
        add("w_hold",   sv(0, 0, 3'b001, 1, 3'b001, 0), ex(c_OVER, 3'b001, 4, 2, 3, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); nm = name_q.pop_front();
            rst = s.rst; start = s.start; guess = s.guess; guess_valid = s.gv; color = s.color;
            if (!s.noclk) @(posedge clk1Hz);
            #1;
            got = w_obs_b;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %h required %h", nm, got, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; guess = 3'd0; guess_valid = 1'b0; color = 3'd0;
        test_reset();
        test_round_hit();
        test_timeout();
        test_black_retry_over();
        test_restart_async_reset();
        test_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not complete, required completion within 20000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
